transformation_block: RTL and testbench
=======================================

// Module: transformation_block
// PURPOSE
//  Pose accumulator for the 3D-to-2D rendering pipeline. Each clock it adds signed
//  translation deltas to the object position and signed angle deltas (degrees) to the
//  X/Y/Z rotation angles. It publishes the accumulated position, the angles reduced to
//  0..359 and the sin/cos of each angle for the downstream rotation/projection stage.
// PARAMETERS
//  W      16     width of translation inputs/outputs and angle-delta inputs
//  TRIG_W 16     width of sin/cos outputs, signed Q1.14 (1.0 = 16384)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous active-low reset
//  dx_coordinate  in   W       signed x translation delta, applied every cycle
//  dy_coordinate  in   W       signed y translation delta
//  dz_coordinate  in   W       signed z translation delta
//  alpha          in   W       signed x-angle delta, degrees
//  beta           in   W       signed y-angle delta, degrees
//  gamma          in   W       signed z-angle delta, degrees
//  pos_x/pos_y/pos_z  out  W   accumulated position, signed
//  ang_x/ang_y/ang_z  out  9   accumulated angle, 0..359
//  sin_x,cos_x,sin_y,cos_y,sin_z,cos_z  out TRIG_W  trig of ang_*, signed Q1.14
// BEHAVIOUR
//  - Port order is clk, rst_n, dx, dy, dz, alpha, beta, gamma, then the outputs.
//    Positional instantiation depends on this order.
//  - Reset: clk is the only clock. rst_n is synchronous and active-low. While rst_n=0
//    at a rising edge, all outputs clear: pos_*=0, ang_*=0, sin_*=0, cos_*=16384.
//    Reset overrides any in-flight update.
//  - Translation: pos_x <= pos_x + dx_coordinate each edge (likewise y, z).
//    Two's-complement wrap on overflow, no saturation.
//  - Angles:
//    * Each delta is taken as signed and reduced to d in 0..359 using a combinational
//      constant-modulus reduction, e.g. -30 -> 330, 390 -> 30, -32768 -> 352.
//    * Update: ang <= ang + d, minus 360 if the sum is >= 360. One conditional
//      subtract, so the result is always 0..359.
//  - Zero deltas hold all state. The block has no enable or handshake, and the inputs
//    are sampled every cycle.
//  - Latency:
//    * pos_* and ang_* reflect an input one cycle after the edge that samples it.
//    * sin_*/cos_* are registered from ang_* and lag ang_* by one further cycle, so
//      there are 2 cycles from input to trig.
//  - Trig:
//    * A 91-entry quarter-wave ROM holds round(16384*sin(k deg)), k=0..90.
//    * Quadrant folding:
//      sin(a) = a<=90 ? T[a] : a<=180 ? T[180-a] : a<=270 ? -T[a-180] : -T[360-a].
//      cos(a) = sin((a+90) mod 360).
//    * Exact values: sin90=16384, sin30=8192, cos150=-14189, sin0=0.
//  - The three axes are independent, with identical datapaths that update in the
//    same cycle.
// TESTING
//  1. Reset for 2 cycles, then all deltas 0 -> pos=0, ang=0, sin=0, cos=16384, and
//     they stay there.
//  2. dx=1 for exactly 2 edges, then 0 -> pos_x=2 and holds. pos_y=pos_z=0.
//  3. alpha=30 for 5 edges, then 0 -> ang_x=150. One cycle later sin_x=8192 and
//     cos_x=-14189.
//  4. ang_x=350, alpha=30 for 1 edge -> ang_x=20. From ang 0, beta=-30 for 1 edge
//     -> ang_y=330. gamma=720 for 1 edge -> ang_z unchanged.
//  5. pos_x=32767, dx=1 -> pos_x=-32768 (wrap).
//  6. With alpha=10 and dx=5 held, drive rst_n=0 for 1 edge -> that edge's outputs
//     are the reset values. Accumulation resumes from 0 at the next edge.

Source files
------------

// File: rtl/transformation_block.sv
// Pose accumulator: integrates signed translation and angle deltas each clock,
// keeps angles in 0..359 and publishes registered sin/cos (Q1.14) per axis.
module transformation_block #(
   parameter int W      = 16,
   parameter int TRIG_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [W-1:0]      dx_coordinate,
   input  logic signed [W-1:0]      dy_coordinate,
   input  logic signed [W-1:0]      dz_coordinate,
   input  logic signed [W-1:0]      alpha,
   input  logic signed [W-1:0]      beta,
   input  logic signed [W-1:0]      gamma,
   output logic signed [W-1:0]      pos_x,
   output logic signed [W-1:0]      pos_y,
   output logic signed [W-1:0]      pos_z,
   output logic        [8:0]        ang_x,
   output logic        [8:0]        ang_y,
   output logic        [8:0]        ang_z,
   output logic signed [TRIG_W-1:0] sin_x,
   output logic signed [TRIG_W-1:0] cos_x,
   output logic signed [TRIG_W-1:0] sin_y,
   output logic signed [TRIG_W-1:0] cos_y,
   output logic signed [TRIG_W-1:0] sin_z,
   output logic signed [TRIG_W-1:0] cos_z
);

   // Quarter-wave table: round(16384 * sin(k deg)), k = 0..90.
   // NOTE: a constant table is not state, so it needs no reset; only registers do.
   localparam int SIN_ROM [91] = '{
          0,   286,   572,   857,  1143,  1428,  1713,  1997,  2280,  2563,
       2845,  3126,  3406,  3686,  3964,  4240,  4516,  4790,  5063,  5334,
       5604,  5872,  6138,  6402,  6664,  6924,  7182,  7438,  7692,  7943,
       8192,  8438,  8682,  8923,  9162,  9397,  9630,  9860, 10087, 10311,
      10531, 10749, 10963, 11174, 11381, 11585, 11786, 11982, 12176, 12365,
      12551, 12733, 12911, 13085, 13255, 13421, 13583, 13741, 13894, 14044,
      14189, 14330, 14466, 14598, 14726, 14849, 14968, 15082, 15191, 15296,
      15396, 15491, 15582, 15668, 15749, 15826, 15897, 15964, 16026, 16083,
      16135, 16182, 16225, 16262, 16294, 16322, 16344, 16362, 16374, 16382,
      16384
   };

   // Reduce a signed degree delta to 0..359 (e.g. -30 -> 330, -32768 -> 352).
   function automatic logic [8:0] reduce_delta(input logic signed [W-1:0] d);
      int r;
      r = int'(d) % 360;
      if (r < 0) r = r + 360;
      return 9'(r);
   endfunction

   // Add two angles in 0..359 with a single conditional subtract of 360.
   function automatic logic [8:0] wrap_add(input logic [8:0] a, input logic [8:0] d);
      logic [9:0] s;
      s = {1'b0, a} + {1'b0, d};
      if (s >= 10'd360) s = s - 10'd360;
      return s[8:0];
   endfunction

   // Quadrant-folded sine lookup for an angle in 0..359.
   function automatic logic signed [TRIG_W-1:0] sin_deg(input logic [8:0] a);
      logic [6:0] idx;
      logic       neg;
      // NOTE: every path assigns idx and neg, so no stale value can be implied.
      idx = 7'(a);
      neg = 1'b0;
      if (a <= 9'd90) begin
         idx = 7'(a);
      end else if (a <= 9'd180) begin
         idx = 7'(9'd180 - a);
      end else if (a <= 9'd270) begin
         idx = 7'(a - 9'd180);
         neg = 1'b1;
      end else begin
         idx = 7'(9'd360 - a);
         neg = 1'b1;
      end
      return neg ? -TRIG_W'(SIN_ROM[idx]) : TRIG_W'(SIN_ROM[idx]);
   endfunction

   logic signed [W-1:0] d_pos [3];
   logic signed [W-1:0] d_ang [3];

   assign d_pos[0] = dx_coordinate;
   assign d_pos[1] = dy_coordinate;
   assign d_pos[2] = dz_coordinate;
   assign d_ang[0] = alpha;
   assign d_ang[1] = beta;
   assign d_ang[2] = gamma;

   for (genvar i = 0; i < 3; i++) begin : g_axis
      logic signed [W-1:0]      pos_r;
      logic        [8:0]        ang_r;
      logic signed [TRIG_W-1:0] sin_r;
      logic signed [TRIG_W-1:0] cos_r;

      // Accumulate position (two's-complement wrap) and angle (mod 360).
      always_ff @(posedge clk) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (!rst_n) begin
            pos_r <= '0;
            ang_r <= '0;
         end else begin
            pos_r <= pos_r + d_pos[i];
            ang_r <= wrap_add(ang_r, reduce_delta(d_ang[i]));
         end
      end

      // Register sin/cos of the accumulated angle, one cycle behind it.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sin_r <= '0;
            cos_r <= TRIG_W'(16384);
         end else begin
            sin_r <= sin_deg(ang_r);
            cos_r <= sin_deg(wrap_add(ang_r, 9'd90));
         end
      end
   end

   assign pos_x = g_axis[0].pos_r;
   assign pos_y = g_axis[1].pos_r;
   assign pos_z = g_axis[2].pos_r;
   assign ang_x = g_axis[0].ang_r;
   assign ang_y = g_axis[1].ang_r;
   assign ang_z = g_axis[2].ang_r;
   assign sin_x = g_axis[0].sin_r;
   assign cos_x = g_axis[0].cos_r;
   assign sin_y = g_axis[1].sin_r;
   assign cos_y = g_axis[1].cos_r;
   assign sin_z = g_axis[2].sin_r;
   assign cos_z = g_axis[2].cos_r;

endmodule

// File: tb/tb_transformation_block.sv
// Directed bench for transformation_block: reset, accumulation, angle wrap,
// trig lookup at quadrant boundaries, position wrap and reset mid-stream.
module tb_transformation_block;

   localparam int W      = 16;
   localparam int TRIG_W = 16;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic signed [W-1:0]      dx_coordinate, dy_coordinate, dz_coordinate;
   logic signed [W-1:0]      alpha, beta, gamma;
   logic signed [W-1:0]      pos_x, pos_y, pos_z;
   logic        [8:0]        ang_x, ang_y, ang_z;
   logic signed [TRIG_W-1:0] sin_x, cos_x, sin_y, cos_y, sin_z, cos_z;

   int tests = 0;
   int fails = 0;

   transformation_block #(.W(W), .TRIG_W(TRIG_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dx_coordinate (dx_coordinate),
      .dy_coordinate (dy_coordinate),
      .dz_coordinate (dz_coordinate),
      .alpha         (alpha),
      .beta          (beta),
      .gamma         (gamma),
      .pos_x         (pos_x),
      .pos_y         (pos_y),
      .pos_z         (pos_z),
      .ang_x         (ang_x),
      .ang_y         (ang_y),
      .ang_z         (ang_z),
      .sin_x         (sin_x),
      .cos_x         (cos_x),
      .sin_y         (sin_y),
      .cos_y         (cos_y),
      .sin_z         (sin_z),
      .cos_z         (cos_z)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   // Compare a sign-extended observation with its expected value.
   task automatic check(input string tag, input int observed, input int expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance n rising edges, then settle 1 unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      dx_coordinate = '0; dy_coordinate = '0; dz_coordinate = '0;
      alpha = '0; beta = '0; gamma = '0;

      // 1. Reset for two edges, then idle.
      step(2);
      check("rst_pos_x", pos_x, 0);
      check("rst_ang_x", ang_x, 0);
      check("rst_sin_x", sin_x, 0);
      check("rst_cos_x", cos_x, 16384);
      check("rst_cos_z", cos_z, 16384);
      rst_n = 1'b1;
      step(3);
      check("idle_pos_y", pos_y, 0);
      check("idle_ang_z", ang_z, 0);
      check("idle_sin_y", sin_y, 0);
      check("idle_cos_y", cos_y, 16384);

      // 2. dx = 1 for two edges.
      dx_coordinate = 16'sd1;
      step(2);
      dx_coordinate = '0;
      check("dx2_pos_x", pos_x, 2);
      step(3);
      check("dx2_hold_pos_x", pos_x, 2);
      check("dx2_pos_y", pos_y, 0);
      check("dx2_pos_z", pos_z, 0);

      // 3. alpha = 30 for five edges -> 150, trig one cycle later.
      alpha = 16'sd30;
      step(5);
      alpha = '0;
      check("a150_ang_x", ang_x, 150);
      step(1);
      check("a150_sin_x", sin_x, 8192);
      check("a150_cos_x", cos_x, -14189);
      check("a150_ang_hold", ang_x, 150);

      // 4. Angle wrap cases.
      alpha = 16'sd200;
      step(1);
      check("a350_ang_x", ang_x, 350);
      alpha = 16'sd30;
      step(1);
      check("wrap_ang_x", ang_x, 20);
      alpha = 16'sh8000;                 // -32768 reduces to 352
      step(1);
      check("min_ang_x", ang_x, 12);
      alpha = 16'sd390;                  // reduces to 30
      step(1);
      check("a390_ang_x", ang_x, 42);
      alpha = '0;
      beta = -16'sd30;
      step(1);
      beta = '0;
      check("neg_ang_y", ang_y, 330);
      gamma = 16'sd720;
      step(1);
      gamma = '0;
      check("g720_ang_z", ang_z, 0);
      check("a330_sin_y", sin_y, -8192);
      check("a330_cos_y", cos_y, 14189);

      // Trig at 90 and 270 degrees.
      gamma = 16'sd90;
      step(1);
      gamma = '0;
      step(1);
      check("a90_sin_z", sin_z, 16384);
      check("a90_cos_z", cos_z, 0);
      gamma = 16'sd180;
      step(1);
      gamma = '0;
      check("a270_ang_z", ang_z, 270);
      step(1);
      check("a270_sin_z", sin_z, -16384);
      check("a270_cos_z", cos_z, 0);

      // 5. Position wrap.
      dx_coordinate = 16'sd32765;
      step(1);
      check("max_pos_x", pos_x, 32767);
      dx_coordinate = 16'sd1;
      step(1);
      check("wrap_pos_x", pos_x, -32768);

      // 6. Reset in the middle of accumulation.
      dx_coordinate = 16'sd5;
      alpha = 16'sd10;
      step(1);
      check("pre_rst_pos_x", pos_x, -32763);
      check("pre_rst_ang_x", ang_x, 52);
      rst_n = 1'b0;
      step(1);
      check("mid_rst_pos_x", pos_x, 0);
      check("mid_rst_ang_x", ang_x, 0);
      check("mid_rst_sin_x", sin_x, 0);
      check("mid_rst_cos_x", cos_x, 16384);
      check("mid_rst_ang_y", ang_y, 0);
      rst_n = 1'b1;
      step(1);
      check("resume_pos_x", pos_x, 5);
      check("resume_ang_x", ang_x, 10);
      check("resume_sin_x", sin_x, 0);
      step(1);
      check("resume2_pos_x", pos_x, 10);
      check("resume2_ang_x", ang_x, 20);
      check("a10_sin_x", sin_x, 2845);
      dx_coordinate = '0;
      alpha = '0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
